// File: rtl/sprite_plotter.sv
// -----------------------------------------------------------------------------
// sprite_plotter
//
// Purpose:
//   Copies a SPRITE_W x SPRITE_H sprite from a synchronous ROM (1-cycle read
//   latency) into a SCREEN_W x SCREEN_H framebuffer. It walks the ROM
//   row-major and emits one registered x/y/colour/plot write per pixel,
//   offset by an origin latched at start. Transparent pixels and pixels that
//   fall off the right/bottom screen edge get vgaPlot=0. The game FSM drives
//   the block with start/busy/done.
//
// Ports:
//   clk         in   1   system clock, all state on rising edge
//   resetn      in   1   asynchronous active-low reset
//   start       in   1   draw request, only sampled while idle
//   originX     in   8   sprite top-left x, latched on acceptance
//   originY     in   7   sprite top-left y, latched on acceptance
//   busy        out  1   draw in progress (walk + pipeline flush)
//   done        out  1   one-cycle pulse after the last pixel is emitted
//   spriteAddr  out  11  sprite ROM address, row*SPRITE_W + col
//   spriteData  in   3   ROM colour, valid the cycle after spriteAddr
//   vgaX        out  8   framebuffer x (registered)
//   vgaY        out  7   framebuffer y (registered)
//   vgaColour   out  3   framebuffer colour (registered)
//   vgaPlot     out  1   framebuffer write strobe (registered)
// -----------------------------------------------------------------------------
module sprite_plotter #(
  parameter int unsigned         SPRITE_W    = 40,
  parameter int unsigned         SPRITE_H    = 40,
  parameter int unsigned         SCREEN_W    = 160,
  parameter int unsigned         SCREEN_H    = 120,
  parameter int unsigned         COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          originX,
  input  logic [6:0]          originY,
  output logic                busy,
  output logic                done,
  output logic [10:0]         spriteAddr,
  input  logic [COLOUR_W-1:0] spriteData,
  output logic [7:0]          vgaX,
  output logic [6:0]          vgaY,
  output logic [COLOUR_W-1:0] vgaColour,
  output logic                vgaPlot
);

  localparam int unsigned COL_W     = $clog2(SPRITE_W);
  localparam int unsigned ROW_W     = $clog2(SPRITE_H);
  localparam logic [10:0] LAST_ADDR = 11'(SPRITE_W * SPRITE_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPRITE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_t;

  // Clip test on the unwrapped sums: a sprite hanging over the right or
  // bottom edge must not wrap around onto the left or top of the screen.
  function automatic logic fn_on_screen(input logic [8:0] x, input logic [7:0] y);
    return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
  endfunction

  function automatic logic fn_plot(input logic                vld,
                                   input logic [COLOUR_W-1:0] colour,
                                   input logic [8:0]          x,
                                   input logic [7:0]          y);
    return vld && (colour != TRANSPARENT) && fn_on_screen(x, y);
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_advance;
  logic                w_last;
  logic                w_busy;
  logic                w_done;

  logic [10:0]         r_addr;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [7:0]          r_origin_x;
  logic [6:0]          r_origin_y;

  logic                vld_p0;
  logic [COL_W-1:0]    r_col_p0;
  logic [ROW_W-1:0]    r_row_p0;
  logic [8:0]          w_x_p0;
  logic [7:0]          w_y_p0;

  logic                vld_p1;
  logic [7:0]          r_x_p1;
  logic [6:0]          r_y_p1;
  logic [COLOUR_W-1:0] r_colour_p1;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_last      = (r_addr == LAST_ADDR);
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DRAW;
        end
      end
      S_DRAW: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DRAIN1;
        end else begin
          w_advance = 1'b1;
        end
      end
      // Two flush cycles: one for the ROM read latency, one for the
      // registered framebuffer outputs.
      S_DRAIN1: begin
        w_busy      = 1'b1;
        w_state_nxt = S_DRAIN2;
      end
      S_DRAIN2: begin
        w_busy      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = w_busy;
  assign done = w_done;

  // ---------------------------------------------------------------------------
  // Address walk: ROM address plus the column/row it corresponds to
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_origin_x <= '0;
      r_origin_y <= '0;
    end else if (w_accept) begin
      r_addr     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_origin_x <= originX;
      r_origin_y <= originY;
    end else if (w_advance) begin
      r_addr <= r_addr + 11'd1;
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign spriteAddr = r_addr;

  // ---------------------------------------------------------------------------
  // Stage p0: position delayed one cycle to line up with spriteData
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= (r_state == S_DRAW);
    end
  end

  always_ff @(posedge clk) begin
    r_col_p0 <= r_col;
    r_row_p0 <= r_row;
  end

  assign w_x_p0 = 9'(r_origin_x) + 9'(r_col_p0);
  assign w_y_p0 = 8'(r_origin_y) + 8'(r_row_p0);

  // ---------------------------------------------------------------------------
  // Stage p1: registered framebuffer write
  // ---------------------------------------------------------------------------
  // Position and colour follow every pixel; only the strobe is qualified.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1      <= 1'b0;
      r_x_p1      <= '0;
      r_y_p1      <= '0;
      r_colour_p1 <= '0;
    end else begin
      vld_p1      <= fn_plot(vld_p0, spriteData, w_x_p0, w_y_p0);
      r_x_p1      <= w_x_p0[7:0];
      r_y_p1      <= w_y_p0[6:0];
      r_colour_p1 <= spriteData;
    end
  end

  assign vgaX      = r_x_p1;
  assign vgaY      = r_y_p1;
  assign vgaColour = r_colour_p1;
  assign vgaPlot   = vld_p1;

endmodule

// File: tb/tb_sprite_plotter.sv
module tb_sprite_plotter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  originX;
  logic [6:0]  originY;
  logic        busy;
  logic        done;
  logic [10:0] spriteAddr;
  logic [2:0]  spriteData = 3'b000;
  logic [7:0]  vgaX;
  logic [6:0]  vgaY;
  logic [2:0]  vgaColour;
  logic        vgaPlot;

  always #10 clk = ~clk;

  sprite_plotter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .originX    (originX),
    .originY    (originY),
    .busy       (busy),
    .done       (done),
    .spriteAddr (spriteAddr),
    .spriteData (spriteData),
    .vgaX       (vgaX),
    .vgaY       (vgaY),
    .vgaColour  (vgaColour),
    .vgaPlot    (vgaPlot)
  );

  // cyc == number of rising edges seen so far; sampled on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sprite ROM: mode 0 = all 3'b101, mode 1 = checkerboard of 3'b010 / 0.
  int rom_mode = 0;

  function automatic logic [2:0] rom_colour(int mode, int a);
    int c;
    int r;
    c = a % 40;
    r = a / 40;
    if (mode == 0) return 3'b101;
    return (((c + r) % 2) == 1) ? 3'b000 : 3'b010;
  endfunction

  always @(posedge clk) spriteData <= rom_colour(rom_mode, int'(spriteAddr));

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } plot_t;

  plot_t exp_q[$];
  int    done_q[$];
  int    log_x[$];
  int    log_y[$];
  int    log_t[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle count %0d)", name, act, exp, cyc);
  endtask

  // Expected writes of one draw accepted with cycle-count t0 at the edge
  // before; pixel n appears at t0+n+3. Writes after last_t are not expected.
  task automatic push_draw(int ox, int oy, int mode, int t0, int last_t);
    plot_t e;
    for (int n = 0; n < 1600; n++) begin
      e.x = ox + (n % 40);
      e.y = oy + (n / 40);
      e.c = int'(rom_colour(mode, n));
      e.t = t0 + n + 3;
      if (e.t <= last_t && e.c != 0 && e.x < 160 && e.y < 120) exp_q.push_back(e);
    end
  endtask

  task automatic monitor();
    plot_t e;
    int    t;
    forever begin
      @(negedge clk);
      if (vgaPlot) begin
        log_x.push_back(int'(vgaX));
        log_y.push_back(int'(vgaY));
        log_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_plot", int'(vgaPlot), 0);
        end else begin
          e = exp_q.pop_front();
          chk("plot_x", int'(vgaX), e.x);
          chk("plot_y", int'(vgaY), e.y);
          chk("plot_colour", int'(vgaColour), e.c);
          chk("plot_cycle", cyc, e.t);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          t = done_q.pop_front();
          chk("done_cycle", cyc, t);
        end
      end
    end
  endtask

  task automatic wait_to(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called on a falling edge; returns at the falling edge of cycle 1.
  task automatic go(int ox, int oy, bit hold, output int t0);
    originX = 8'(ox);
    originY = 7'(oy);
    start   = 1'b1;
    t0      = cyc;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_cycle1", int'(busy), 1);
    chk("addr_cycle1", int'(spriteAddr), 0);
  endtask

  task automatic queues_empty(string tag);
    chk({tag, "_plots_left"}, exp_q.size(), 0);
    chk({tag, "_dones_left"}, done_q.size(), 0);
  endtask

  task automatic stimulus();
    int t0;
    int t1;
    int base;
    resetn  = 1'b0;
    start   = 1'b0;
    originX = '0;
    originY = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(spriteAddr), 0);
    chk("rst_plot", int'(vgaPlot), 0);
    chk("rst_x", int'(vgaX), 0);
    chk("rst_y", int'(vgaY), 0);
    chk("rst_colour", int'(vgaColour), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: opaque sprite at (10,20)
    rom_mode = 0;
    base = log_x.size();
    go(10, 20, 1'b0, t0);
    push_draw(10, 20, 0, t0, t0 + 5000);
    done_q.push_back(t0 + 1603);
    wait_to(t0 + 1602);
    chk("t1_busy_1602", int'(busy), 1);
    chk("t1_addr_hold", int'(spriteAddr), 1599);
    wait_to(t0 + 1603);
    chk("t1_busy_1603", int'(busy), 0);
    chk("t1_done_1603", int'(done), 1);
    wait_to(t0 + 1604);
    chk("t1_done_1604", int'(done), 0);
    wait_to(t0 + 1608);
    queues_empty("t1");
    chk("t1_count", log_x.size() - base, 1600);
    chk("t1_first_x", log_x[base], 10);
    chk("t1_first_y", log_y[base], 20);
    chk("t1_first_t", log_t[base] - t0, 3);
    chk("t1_last_x", log_x[base + 1599], 49);
    chk("t1_last_y", log_y[base + 1599], 59);
    chk("t1_last_t", log_t[base + 1599] - t0, 1602);

    // 2: checkerboard at (0,0)
    rom_mode = 1;
    base = log_x.size();
    go(0, 0, 1'b0, t0);
    push_draw(0, 0, 1, t0, t0 + 5000);
    done_q.push_back(t0 + 1603);
    wait_to(t0 + 41);
    chk("t2_addr_41", int'(spriteAddr), 40);
    wait_to(t0 + 1608);
    queues_empty("t2");
    chk("t2_count", log_x.size() - base, 800);
    chk("t2_first_x", log_x[base], 0);
    chk("t2_first_t", log_t[base] - t0, 3);
    chk("t2_second_x", log_x[base + 1], 2);
    chk("t2_second_t", log_t[base + 1] - t0, 5);
    chk("t2_last_x", log_x[base + 799], 39);
    chk("t2_last_y", log_y[base + 799], 39);

    // 3: clipping at (140,100)
    rom_mode = 0;
    base = log_x.size();
    go(140, 100, 1'b0, t0);
    push_draw(140, 100, 0, t0, t0 + 5000);
    done_q.push_back(t0 + 1603);
    wait_to(t0 + 1608);
    queues_empty("t3");
    chk("t3_count", log_x.size() - base, 400);
    chk("t3_first_x", log_x[base], 140);
    chk("t3_first_y", log_y[base], 100);
    chk("t3_last_x", log_x[base + 399], 159);
    chk("t3_last_y", log_y[base + 399], 119);
    chk("t3_last_t", log_t[base + 399] - t0, 782);

    // 4: start with a new origin mid-draw is ignored
    base = log_x.size();
    go(5, 5, 1'b0, t0);
    push_draw(5, 5, 0, t0, t0 + 5000);
    done_q.push_back(t0 + 1603);
    wait_to(t0 + 500);
    originX = 8'd90;
    originY = 7'd60;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_busy_501", int'(busy), 1);
    wait_to(t0 + 1610);
    queues_empty("t4");
    chk("t4_count", log_x.size() - base, 1600);
    chk("t4_last_x", log_x[base + 1599], 44);
    chk("t4_last_y", log_y[base + 1599], 44);

    // 5: reset at cycle 700 aborts; then a full draw
    base = log_x.size();
    go(0, 0, 1'b0, t0);
    push_draw(0, 0, 0, t0, t0 + 700);
    wait_to(t0 + 700);
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_done", int'(done), 0);
    chk("t5_rst_plot", int'(vgaPlot), 0);
    chk("t5_rst_addr", int'(spriteAddr), 0);
    chk("t5_rst_x", int'(vgaX), 0);
    chk("t5_rst_y", int'(vgaY), 0);
    chk("t5_rst_colour", int'(vgaColour), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    queues_empty("t5a");
    chk("t5_abort_count", log_x.size() - base, 698);
    base = log_x.size();
    go(0, 0, 1'b0, t0);
    push_draw(0, 0, 0, t0, t0 + 5000);
    done_q.push_back(t0 + 1603);
    wait_to(t0 + 1608);
    queues_empty("t5b");
    chk("t5_count", log_x.size() - base, 1600);

    // 6: start held high -> back-to-back draws
    base = log_x.size();
    go(30, 40, 1'b1, t0);
    t1 = t0 + 1604;
    push_draw(30, 40, 0, t0, t0 + 5000);
    push_draw(30, 40, 0, t1, t1 + 5000);
    done_q.push_back(t0 + 1603);
    done_q.push_back(t0 + 3207);
    wait_to(t0 + 1603);
    chk("t6_busy_1603", int'(busy), 0);
    chk("t6_done_1603", int'(done), 1);
    wait_to(t0 + 1605);
    chk("t6_busy_1605", int'(busy), 1);
    chk("t6_addr_1605", int'(spriteAddr), 0);
    wait_to(t0 + 2000);
    start = 1'b0;
    wait_to(t0 + 3207);
    chk("t6_done_3207", int'(done), 1);
    chk("t6_busy_3207", int'(busy), 0);
    wait_to(t0 + 3212);
    queues_empty("t6");
    chk("t6_count", log_x.size() - base, 3200);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #2000000;
        $display("FAIL timeout: got no end of stimulus, expected completion (cycle count %0d)", cyc);
        $fatal(1);
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
